fp_add_alu: RTL and testbench
=============================

FP_ADD_ALU -- requirements
Module: fp_add_alu

Interface
REQ-001 Parameters: none; the format is fixed to IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  a/b carry an operand pair this cycle.
REQ-005 a  input  32  operand A, binary32.
REQ-006 b  input  32  operand B, binary32.
REQ-007 out_valid  output  1  sum is valid this cycle.
REQ-008 sum  output  32  binary32 result of a + b.

Function
REQ-009 The block SHALL be a 3-stage pipeline: stage 1 mask, stage 2 align, stage 3 ALU + normalize + round; each stage SHALL end in a register.
REQ-010 Latency SHALL be exactly 3 cycles: a pair sampled at edge N with in_valid=1 SHALL appear with out_valid=1 after edge N+3.
REQ-011 Throughput SHALL be one pair per cycle; there is no backpressure; bubbles (in_valid=0) SHALL propagate as out_valid=0.
REQ-012 When out_valid=0, sum SHALL hold its last value.
REQ-013 Mask: split each operand into sign[31], exponent[30:23] and fraction[22:0]; the significand SHALL be {1, fraction} for exp 1..254.
REQ-014 Mask: exponent 0 (zero or denormal) SHALL be treated as signed zero (flush-to-zero on input).
REQ-015 Mask: classify each operand as zero, normal, infinity (exp 255, frac 0) or NaN (exp 255, frac != 0).
REQ-016 Align: swap operands so the larger magnitude is first, compared on {exp, frac}.
REQ-017 Align: shift the smaller significand right by the exponent difference into a 27-bit datapath (24 significand + guard + round + sticky); every bit shifted past sticky SHALL be ORed into sticky; a difference of 26 or more SHALL leave only sticky.
REQ-018 ALU: equal signs SHALL add the significands; different signs SHALL subtract smaller from larger; the result sign SHALL be the sign of the larger operand.
REQ-019 Normalize: on carry-out, shift right 1 and increment the exponent; otherwise shift left by the leading-zero count and decrement the exponent.
REQ-020 Rounding SHALL be round-to-nearest, ties-to-even, using guard/round/sticky; a mantissa overflow from rounding SHALL renormalize.
REQ-021 A biased result exponent of 255 or more SHALL give signed infinity (sign,8'hFF,23'h0).
REQ-022 A result exponent of 0 or less SHALL give signed zero (flush-to-zero on output).
REQ-023 An exact-zero difference SHALL give +0 (32'h00000000); -0 + -0 SHALL give 32'h80000000.
REQ-024 Any NaN input, or +inf + -inf, SHALL give the canonical quiet NaN 32'h7FC00000.
REQ-025 Infinity plus any finite value SHALL give that infinity; inf + inf of the same sign SHALL give that infinity.
REQ-026 Zero plus a normal x SHALL give x bit-exactly.

Reset
REQ-027 When rst_n=0, all valid flags SHALL clear to 0 immediately and asynchronously, and sum SHALL clear to 32'h00000000.
REQ-028 Operations in flight at reset SHALL be discarded; after rst_n rises, the first out_valid SHALL come 3 cycles after the first accepted in_valid.
REQ-029 Datapath registers other than sum MAY be left unreset.

Structure
REQ-030 Package fp_add_pkg SHALL hold: typedef fp32_t (packed sign/exp/frac struct), the class enum {ZERO, NORM, INF, NAN}, and constants BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, and the 27-bit datapath width.
REQ-031 The design SHALL use one sub-module, fp_lzc: a 27-bit leading-zero counter with a 5-bit output, used by stage 3.
REQ-032 The mask, align and ALU stages SHALL be always_ff/always_comb blocks inside fp_add_alu.

Verification
REQ-033 a=3F800000, b=3F800000, in_valid=1 at cycle 0 -> sum=40000000, out_valid=1 at cycle 3 only.
REQ-034 a=3FC00000, b=BFC00000 -> sum=00000000; a=3F800000, b=33800000 (tie) -> sum=3F800000 (ties-to-even).
REQ-035 a=7F7FFFFF, b=7F7FFFFF -> 7F800000; a=7F800000, b=FF800000 -> 7FC00000; a=7FC00001, b=3F800000 -> 7FC00000.
REQ-036 Back-to-back pairs on 3 consecutive cycles, then drop rst_n mid-stream -> out_valid=0 and sum=0 immediately; no stale result after release.
REQ-037 10000 random a/b pairs with random in_valid -> every sum matches a round-to-nearest-even, flush-to-zero reference model, with 3-cycle alignment.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types and constants for the binary32 adder pipeline.
package fp_add_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  // 24-bit significand plus guard, round and sticky
  localparam int          DP_W    = 27;

  // Exponent 0 (zero or denormal) is treated as zero.
  function automatic fp_class_t classify(input fp32_t x);
    if (x.exp == 8'd0) return ZERO;
    if (x.exp == 8'(EXP_MAX)) return (x.frac == 23'd0) ? INF : NAN;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_add_if.sv
// Operand/result bus of the binary32 adder.
interface fp_add_if;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] sum;

  modport master (output in_valid, a, b, input out_valid, sum);
  modport slave  (input in_valid, a, b, output out_valid, sum);
endinterface

// File: rtl/fp_lzc.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module fp_lzc
  import fp_add_pkg::*;
(
  input  logic [DP_W-1:0] din,
  output logic [4:0]      cnt
);

  // Scan upward so the highest set bit decides the count
  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < DP_W; i++) begin
      if (din[i]) cnt = 5'(DP_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_alu.sv
// Three-stage binary32 adder: mask, align, add/normalize/round.
// Round-to-nearest-even with flush-to-zero on inputs and outputs.
module fp_add_alu
  import fp_add_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  fp_add_if.slave bus
);

  localparam logic signed [9:0] EXP_OVF = 10'(EXP_MAX);

  // Right shift that folds every bit pushed past the sticky position into sticky.
  function automatic logic [DP_W-1:0] shift_sticky(input logic [DP_W-1:0] v,
                                                   input logic [7:0]      sh);
    logic [DP_W-1:0] lost_mask;
    logic [DP_W-1:0] r;
    if (sh >= 8'd26) return {{(DP_W-1){1'b0}}, |v};
    lost_mask = (DP_W'(1) << sh) - DP_W'(1);
    r         = v >> sh;
    r[0]      = r[0] | (|(v & lost_mask));
    return r;
  endfunction

  // Ties-to-even rounding on G/R/S, then overflow to infinity / underflow to zero.
  function automatic logic [31:0] round_pack(input logic              sign,
                                             input logic signed [9:0] exp_in,
                                             input logic [DP_W-1:0]   m);
    logic              round_up;
    logic [24:0]       sig_r;
    logic signed [9:0] exp_r;
    round_up = m[2] & (m[1] | m[0] | m[3]);
    sig_r    = {1'b0, m[DP_W-1:3]} + 25'(round_up);
    exp_r    = exp_in;
    if (sig_r[24]) begin
      sig_r = sig_r >> 1;
      exp_r = exp_in + 10'sd1;
    end
    if (exp_r >= EXP_OVF) return {sign, 8'hFF, 23'd0};
    if (exp_r <= 10'sd0)  return {sign, 31'd0};
    return {sign, exp_r[7:0], sig_r[22:0]};
  endfunction

  // ---------------- stage 1: mask ----------------
  fp32_t op_a, op_b;
  assign op_a = bus.a;
  assign op_b = bus.b;

  logic        sign_a_p0, sign_b_p0;
  logic [7:0]  exp_a_p0, exp_b_p0;
  logic [22:0] frac_a_p0, frac_b_p0;
  fp_class_t   cls_a_p0, cls_b_p0;
  logic        vld_p0;

  // Split fields, flush denormal fractions, classify both operands
  always_ff @(posedge clk) begin
    sign_a_p0 <= op_a.sign;
    sign_b_p0 <= op_b.sign;
    exp_a_p0  <= op_a.exp;
    exp_b_p0  <= op_b.exp;
    frac_a_p0 <= (op_a.exp == 8'd0) ? 23'd0 : op_a.frac;
    frac_b_p0 <= (op_b.exp == 8'd0) ? 23'd0 : op_b.frac;
    cls_a_p0  <= classify(op_a);
    cls_b_p0  <= classify(op_b);
  end

  // Stage 1 valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= bus.in_valid;
  end

  // ---------------- stage 2: align ----------------
  logic            a_big, s_big;
  logic [7:0]      e_big, e_small, exp_diff;
  logic [22:0]     f_big, f_small;
  logic [DP_W-1:0] big_al, small_al;
  logic            special;
  logic [31:0]     special_val;

  logic            sign_p1, sub_p1, special_p1, vld_p1;
  logic [7:0]      exp_p1;
  logic [DP_W-1:0] big_p1, small_p1;
  logic [31:0]     special_val_p1;

  // Order by magnitude, align the smaller significand, resolve special operands
  always_comb begin
    a_big = {exp_a_p0, frac_a_p0} >= {exp_b_p0, frac_b_p0};
    if (a_big) begin
      s_big = sign_a_p0; e_big = exp_a_p0; f_big = frac_a_p0;
      e_small = exp_b_p0; f_small = frac_b_p0;
    end else begin
      s_big = sign_b_p0; e_big = exp_b_p0; f_big = frac_b_p0;
      e_small = exp_a_p0; f_small = frac_a_p0;
    end
    exp_diff = e_big - e_small;
    big_al   = {(e_big != 8'd0), f_big, 3'b000};
    small_al = shift_sticky({(e_small != 8'd0), f_small, 3'b000}, exp_diff);

    special     = 1'b1;
    special_val = 32'd0;
    if (cls_a_p0 == NAN || cls_b_p0 == NAN ||
        (cls_a_p0 == INF && cls_b_p0 == INF && sign_a_p0 != sign_b_p0))
      special_val = QNAN;
    else if (cls_a_p0 == INF)
      special_val = {sign_a_p0, 8'hFF, 23'd0};
    else if (cls_b_p0 == INF)
      special_val = {sign_b_p0, 8'hFF, 23'd0};
    else if (cls_a_p0 == ZERO && cls_b_p0 == ZERO)
      special_val = {sign_a_p0 & sign_b_p0, 31'd0};
    else
      special = 1'b0;
  end

  // Stage 2 data registers
  always_ff @(posedge clk) begin
    sign_p1        <= s_big;
    sub_p1         <= sign_a_p0 ^ sign_b_p0;
    exp_p1         <= e_big;
    big_p1         <= big_al;
    small_p1       <= small_al;
    special_p1     <= special;
    special_val_p1 <= special_val;
  end

  // Stage 2 valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  // ---------------- stage 3: ALU + normalize + round ----------------
  logic [DP_W:0]     raw;
  logic [DP_W-1:0]   norm;
  logic [4:0]        lz;
  logic signed [9:0] exp_n;
  logic [31:0]       result;
  logic              vld_p2;
  logic [31:0]       sum_p2;

  fp_lzc u_lzc (
    .din (raw[DP_W-1:0]),
    .cnt (lz)
  );

  // Add or subtract magnitudes, normalize, round and pack
  always_comb begin
    raw = sub_p1 ? ({1'b0, big_p1} - {1'b0, small_p1})
                 : ({1'b0, big_p1} + {1'b0, small_p1});
    if (raw[DP_W]) begin
      norm  = {raw[DP_W:2], raw[1] | raw[0]};
      exp_n = $signed({2'b00, exp_p1}) + 10'sd1;
    end else begin
      norm  = raw[DP_W-1:0] << lz;
      exp_n = $signed({2'b00, exp_p1}) - $signed({5'd0, lz});
    end
    if (special_p1)         result = special_val_p1;
    else if (raw == '0)     result = 32'd0;
    else                    result = round_pack(sign_p1, exp_n, norm);
  end

  // Output register; sum holds between valid results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      sum_p2 <= 32'd0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) sum_p2 <= result;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.sum       = sum_p2;

endmodule

// File: tb/tb_fp_add_alu.sv
// Bench for fp_add_alu: directed corner cases, mid-stream reset and
// randomized traffic against a real-arithmetic reference model.
module tb_fp_add_alu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_add_if bus();

  fp_add_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] s;
  } exp_t;

  exp_t        pipe[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_sum;

  // Exact widening of a binary32 (denormals flushed) to a double
  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) d = {x[31], 63'd0};
    else                  d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Reference: specials by rule, otherwise double sum rounded RNE to binary32
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic        xn, yn, xi, yi;
    real         r;
    logic [63:0] d;
    int          e;
    logic [24:0] sig;
    logic [28:0] rem;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    if (xn || yn || (xi && yi && x[31] != y[31])) return 32'h7FC0_0000;
    if (xi) return x;
    if (yi) return y;
    r = to_real(x) + to_real(y);
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e   = int'(d[62:52]) - 896;
    sig = {2'b01, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && sig[0])) sig = sig + 25'd1;
    if (sig[24]) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(e), sig[22:0]};
  endfunction

  function automatic logic [31:0] rnd_b(input logic [31:0] a);
    logic [31:0] x;
    int          k;
    x = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3: x[30:23] = a[30:23] - 8'($urandom_range(0, 30));
      4:          begin x[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) x[22:0] = 23'd0; end
      5:          x[30:23] = 8'd0;
      6:          x = a ^ 32'h8000_0000;
      7:          x[30:23] = 8'd254 - 8'($urandom_range(0, 2));
      default:    ;
    endcase
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
  endtask

  // One clock: check what leaves the pipe, then present the next pair
  task automatic step(input logic v, input logic [31:0] xa, input logic [31:0] xb,
                      input logic [31:0] want, input logic use_want);
    exp_t  e, n;
    string tag;
    @(posedge clk);
    #1;
    e = pipe.pop_front();
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, e.v});
    if (e.v) last_sum = e.s;
    tag = e.v ? "sum" : "sum_hold";
    check(tag, bus.sum, last_sum);
    bus.in_valid = v;
    bus.a        = xa;
    bus.b        = xb;
    n.v = v;
    n.s = use_want ? want : ref_add(xa, xb);
    pipe.push_back(n);
  endtask

  task automatic pipe_clear();
    exp_t z;
    z.v = 1'b0;
    z.s = 32'd0;
    pipe.delete();
    repeat (3) pipe.push_back(z);
    last_sum = 32'd0;
  endtask

  task automatic dir(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] want);
    step(1'b1, xa, xb, want, 1'b1);
  endtask

  task automatic bubbles(input int n);
    repeat (n) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sum", bus.sum, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    pipe_clear();

    // Directed corner cases
    dir(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    bubbles(4);
    dir(32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000);
    dir(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    dir(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
    dir(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    dir(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    dir(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    dir(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    dir(32'h0000_0000, 32'h4049_0FDB, 32'h4049_0FDB);
    dir(32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
    dir(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000);
    dir(32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000);
    dir(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    dir(32'h0080_0000, 32'h8080_0001, 32'h8000_0000);
    dir(32'h4B80_0000, 32'hBF80_0000, 32'h4B7F_FFFF);
    bubbles(4);

    // Back-to-back pairs, then reset mid-stream
    dir(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    dir(32'h4040_0000, 32'h3F80_0000, 32'h4080_0000);
    dir(32'h4080_0000, 32'h4080_0000, 32'h4100_0000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_sum", bus.sum, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    pipe_clear();
    bubbles(5);
    dir(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    bubbles(4);

    // Randomized traffic with random bubbles
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 15) == 0) ra[30:23] = 8'd0;
      rb = rnd_b(ra);
      if ($urandom_range(0, 1) == 0) step($urandom_range(0, 3) != 0, ra, rb, 32'd0, 1'b0);
      else                           step($urandom_range(0, 3) != 0, rb, ra, 32'd0, 1'b0);
    end
    bubbles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
